alu_seq: RTL and testbench

//  Registered, parametrised successor to the MCU's combinational ALU. Keeps the 3-bit op map,

---
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with Z/C/N flags and valid/ready handshake on both sides.
// Optional iterative shift-add multiply on op 111 when ALU_MUL_EN is defined.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n
);

  logic             accept;
  logic             busy;
  logic             is_mul;
  logic [WIDTH-1:0] res;
  logic             cry;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Result slot is free, or is being drained by the consumer this cycle.
  assign in_ready = ~busy & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    cry = 1'b0;
    case (op)
      3'b000: res = a;
      3'b001: begin res = diff[WIDTH-1:0]; cry = diff[WIDTH]; end
      3'b010: begin res = sum[WIDTH-1:0];  cry = sum[WIDTH];  end
      3'b011: res = a & b;
      3'b100: res = a ^ b;
      3'b101: res = b;
      3'b110: res = a;
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH:0]     p_sum;
  logic               mul_done;

  assign is_mul   = (op == 3'b111);
  assign busy     = (state == S_MUL);
  assign mul_done = busy & (cnt == CNT_W'(WIDTH - 1));

  // Upper half accumulates the multiplicand; lower half holds the remaining
  // multiplier bits, consumed LSB first as the pair shifts right.
  assign p_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
  assign p_nxt = {p_sum, p[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_done)         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      p     <= '0;
    end else if (accept && is_mul) begin
      cnt   <= '0;
      mcand <= a;
      p     <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      cnt   <= cnt + 1'b1;
      p     <= p_nxt;
    end
  end
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      y         <= res;
      y_hi      <= '0;
      flag_z    <= (res == '0);
      flag_c    <= cry;
      flag_n    <= res[WIDTH-1];
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      out_valid <= 1'b1;
      y         <= p_nxt[WIDTH-1:0];
      y_hi      <= p_nxt[2*WIDTH-1:WIDTH];
      flag_z    <= (p_nxt == '0);
      flag_c    <= 1'b0;
      flag_n    <= p_nxt[2*WIDTH-1];
    end
`endif
    else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y, y_hi;
  logic [2:0]   op;
  logic         flag_z, flag_c, flag_n;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    in_valid = v; op = o; a = aa; b = bb;
  endtask

  logic [W-1:0] sweep_exp [7];
  logic [W-1:0] b2b_a [4];
  logic [W-1:0] b2b_b [4];
  logic [W-1:0] b2b_y [4];

  initial begin
    sweep_exp = '{8'h5A, 8'h1E, 8'h96, 8'h18, 8'h66, 8'h3C, 8'h5A};
    b2b_a     = '{8'h01, 8'h02, 8'h10, 8'hFF};
    b2b_b     = '{8'h01, 8'h03, 8'h20, 8'h01};
    b2b_y     = '{8'h02, 8'h05, 8'h30, 8'h00};

    // Reset with in_valid high
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b1, 3'b010, 8'h11, 8'h22);
    step(); step();
    chk("rst out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst y", {8'd0, y}, 16'd0);
    chk("rst y_hi", {8'd0, y_hi}, 16'd0);
    chk("rst flags", {13'd0, flag_z, flag_c, flag_n}, 16'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", {15'd0, in_ready}, 16'd1);

    // ADD with carry, then SUB with borrow, back to back
    drive(1'b1, 3'b010, 8'hF0, 8'h20);
    step();
    chk("add valid", {15'd0, out_valid}, 16'd1);
    chk("add y", {8'd0, y}, 16'h10);
    chk("add zcn", {13'd0, flag_z, flag_c, flag_n}, 16'b010);
    drive(1'b1, 3'b001, 8'h05, 8'h07);
    step();
    chk("sub y", {8'd0, y}, 16'hFE);
    chk("sub zcn", {13'd0, flag_z, flag_c, flag_n}, 16'b011);

    // Op sweep, one result per cycle
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'(i), 8'h5A, 8'h3C);
      step();
      chk($sformatf("sweep op%0d valid", i), {15'd0, out_valid}, 16'd1);
      chk($sformatf("sweep op%0d y", i), {8'd0, y}, {8'd0, sweep_exp[i]});
      chk($sformatf("sweep op%0d y_hi", i), {8'd0, y_hi}, 16'd0);
    end
    in_valid = 1'b0;
    step();
    chk("idle valid", {15'd0, out_valid}, 16'd0);

    // Backpressure: ADD held for 5 cycles while XOR waits
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 8'h01, 8'h02);
    step();
    chk("bp add y", {8'd0, y}, 16'h03);
    drive(1'b1, 3'b100, 8'h0F, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d in_ready", i), {15'd0, in_ready}, 16'd0);
      chk($sformatf("bp%0d valid", i), {15'd0, out_valid}, 16'd1);
      chk($sformatf("bp%0d y", i), {8'd0, y}, 16'h03);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {15'd0, in_ready}, 16'd1);
    step();
    chk("bp xor valid", {15'd0, out_valid}, 16'd1);
    chk("bp xor y", {8'd0, y}, 16'hFF);
    chk("bp xor zcn", {13'd0, flag_z, flag_c, flag_n}, 16'b001);
    in_valid = 1'b0;
    step();
    chk("bp drained", {15'd0, out_valid}, 16'd0);

    // Four back-to-back ADDs
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b010, b2b_a[i], b2b_b[i]);
      step();
      chk($sformatf("b2b%0d valid", i), {15'd0, out_valid}, 16'd1);
      chk($sformatf("b2b%0d y", i), {8'd0, y}, {8'd0, b2b_y[i]});
    end
    chk("b2b last zc", {14'd0, flag_z, flag_c}, 16'b11);
    in_valid = 1'b0;
    step();
    chk("b2b drained", {15'd0, out_valid}, 16'd0);

    // Op 111
    drive(1'b1, 3'b111, 8'hFF, 8'hFF);
    step();
`ifdef ALU_MUL_EN
    in_valid = 1'b0;
    chk("mul busy in_ready", {15'd0, in_ready}, 16'd0);
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("mul cyc%0d valid", k), {15'd0, out_valid}, 16'd0);
      step();
    end
    chk("mul valid", {15'd0, out_valid}, 16'd1);
    chk("mul y", {8'd0, y}, 16'h01);
    chk("mul y_hi", {8'd0, y_hi}, 16'hFE);
    chk("mul zcn", {13'd0, flag_z, flag_c, flag_n}, 16'b001);
    step();
    chk("mul drained", {15'd0, out_valid}, 16'd0);

    // Reset pulsed mid-multiply
    drive(1'b1, 3'b111, 8'hFF, 8'hFF);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mulrst valid", {15'd0, out_valid}, 16'd0);
    chk("mulrst y", {8'd0, y}, 16'd0);
    chk("mulrst y_hi", {8'd0, y_hi}, 16'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mulrst in_ready", {15'd0, in_ready}, 16'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (out_valid) seen++;
      end
      chk("mulrst no result", 16'(seen), 16'd0);
    end
`else
    in_valid = 1'b0;
    chk("op7 valid", {15'd0, out_valid}, 16'd1);
    chk("op7 y", {8'd0, y}, 16'd0);
    chk("op7 y_hi", {8'd0, y_hi}, 16'd0);
    chk("op7 zcn", {13'd0, flag_z, flag_c, flag_n}, 16'b100);
    step();
    chk("op7 drained", {15'd0, out_valid}, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
